// File: rtl/max_accum.sv
// max_accum -- per-frame signed maximum and tie counter.
//
// Samples arrive in sign-magnitude form and are converted to two's complement.
// Each frame is FRAME_LEN accepted samples (legal range 2..16). At the end of a
// frame the maximum, and the number of later samples that equalled it, are
// presented on a valid/ready output. The block holds the result, and refuses
// input, until the consumer takes the result.
//
// Optional feature: define MAX_ACCUM_MIN_EN to add the out_min port. It carries
// the signed frame minimum, with the same load, update and hold rules as out_max.
module max_accum #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_max,
`ifdef MAX_ACCUM_MIN_EN
    output logic [7:0] out_min,
`endif
    output logic [3:0] out_ties
);

    // Wide enough to hold 16, the largest legal frame length.
    localparam int                CNT_W       = 5;
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [3:0]       TIES_MAX    = 4'd15;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Converts sign-magnitude to two's complement. Negative zero becomes zero.
    function automatic logic signed [7:0] sm_to_tc(input logic [7:0] sm);
        logic signed [7:0] mag;
        mag = $signed({1'b0, sm[6:0]});
        if (sm[7]) begin
            return -mag;
        end else begin
            return mag;
        end
    endfunction

    state_t                   state_r;
    state_t                   next_state_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_nxt_s;
    logic signed [7:0]        max_r;
    logic signed [7:0]        max_nxt_s;
    logic [3:0]               ties_r;
    logic [3:0]               ties_nxt_s;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [7:0]               out_max_r;
    logic [3:0]               out_ties_r;
    logic                     accept_s;
    logic                     load_out_s;
    logic signed [7:0]        sample_s;
`ifdef MAX_ACCUM_MIN_EN
    logic signed [7:0]        min_r;
    logic signed [7:0]        min_nxt_s;
    logic [7:0]               out_min_r;
`endif

    assign accept_s = in_valid & in_ready_r;
    assign sample_s = sm_to_tc(in_data);

    // Next-state and running-statistics update for the frame FSM.
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        max_nxt_s    = max_r;
        ties_nxt_s   = ties_r;
`ifdef MAX_ACCUM_MIN_EN
        min_nxt_s    = min_r;
`endif
        case (state_r)
            FIRST: begin
                if (accept_s) begin
                    max_nxt_s    = sample_s;
                    ties_nxt_s   = 4'd0;
                    cnt_nxt_s    = CNT_W'(1);
`ifdef MAX_ACCUM_MIN_EN
                    min_nxt_s    = sample_s;
`endif
                    // FRAME_LEN is at least 2, so a frame never ends here.
                    next_state_s = ACCUM;
                end else begin
                    next_state_s = FIRST;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    if (sample_s > max_r) begin
                        max_nxt_s  = sample_s;
                        ties_nxt_s = 4'd0;
                    end else if (sample_s == max_r) begin
                        if (ties_r != TIES_MAX) begin
                            ties_nxt_s = ties_r + 4'd1;
                        end else begin
                            ties_nxt_s = ties_r;
                        end
                    end else begin
                        max_nxt_s = max_r;
                    end
`ifdef MAX_ACCUM_MIN_EN
                    if (sample_s < min_r) begin
                        min_nxt_s = sample_s;
                    end else begin
                        min_nxt_s = min_r;
                    end
`endif
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                    if ((cnt_r + CNT_W'(1)) == FRAME_LEN_C) begin
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = ACCUM;
                    end
                end else begin
                    next_state_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // The handoff cycle never accepts a sample. in_ready
                    // comes back on the following cycle.
                    cnt_nxt_s    = CNT_W'(0);
                    next_state_s = FIRST;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = FIRST;
                cnt_nxt_s    = CNT_W'(0);
            end
        endcase
    end

    // The result registers load only when a frame completes.
    assign load_out_s = (state_r != HOLD) && (next_state_s == HOLD);

    // FSM state and running frame statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FIRST;
            cnt_r   <= CNT_W'(0);
            max_r   <= 8'sd0;
            ties_r  <= 4'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_nxt_s;
            max_r   <= max_nxt_s;
            ties_r  <= ties_nxt_s;
        end
    end

    // Handshake flags registered from the next state so that they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s != HOLD);
            out_valid_r <= (next_state_s == HOLD);
        end
    end

    // Result registers. They capture the final frame values, including the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_max_r  <= 8'h00;
            out_ties_r <= 4'd0;
        end else if (load_out_s) begin
            out_max_r  <= max_nxt_s;
            out_ties_r <= ties_nxt_s;
        end else begin
            out_max_r  <= out_max_r;
            out_ties_r <= out_ties_r;
        end
    end

`ifdef MAX_ACCUM_MIN_EN
    // Running minimum and its result register, which follow the maximum's rules.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_r     <= 8'sd0;
            out_min_r <= 8'h00;
        end else begin
            min_r <= min_nxt_s;
            if (load_out_s) begin
                out_min_r <= min_nxt_s;
            end else begin
                out_min_r <= out_min_r;
            end
        end
    end

    assign out_min = out_min_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_max   = out_max_r;
    assign out_ties  = out_ties_r;

endmodule

// File: tb/tb_max_accum.sv
// tb_max_accum -- directed and randomised self-checking bench for max_accum.
// Two instances are used: FRAME_LEN=4 (dut4) and FRAME_LEN=16 (dut16).
// Define MAX_ACCUM_MIN_EN to also check out_min.
module tb_max_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv4, ir4, ov4, or4;
    logic [7:0] id4, om4;
    logic [3:0] ot4;
    logic       iv16, ir16, ov16, or16;
    logic [7:0] id16, om16;
    logic [3:0] ot16;
`ifdef MAX_ACCUM_MIN_EN
    logic [7:0] omin4, omin16;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state for the random frames.
    int m_n, m_max, m_min, m_ties;

    always #5 clk = ~clk;

    max_accum #(.FRAME_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_max(om4),
`ifdef MAX_ACCUM_MIN_EN
        .out_min(omin4),
`endif
        .out_ties(ot4)
    );

    max_accum #(.FRAME_LEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .in_data(id16),
        .out_valid(ov16), .out_ready(or16), .out_max(om16),
`ifdef MAX_ACCUM_MIN_EN
        .out_min(omin16),
`endif
        .out_ties(ot16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge. Offers one sample to dut4 and returns at the negedge after it is accepted.
    task automatic send4(input logic [7:0] d);
        int n;
        n = 0;
        iv4 = 1'b1;
        id4 = d;
        while (!ir4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send4_timeout", 32'(ir4), 32'd1);
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic send16(input logic [7:0] d);
        int n;
        n = 0;
        iv16 = 1'b1;
        id16 = d;
        while (!ir16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send16_timeout", 32'(ir16), 32'd1);
        @(negedge clk);
        iv16 = 1'b0;
    endtask

    task automatic model_add(input logic [7:0] d);
        int v;
        v = d[7] ? -int'(d[6:0]) : int'(d[6:0]);
        if (m_n == 0) begin
            m_max = v; m_min = v; m_ties = 0;
        end else begin
            if (v > m_max) begin
                m_max = v; m_ties = 0;
            end else if (v == m_max && m_ties < 15) begin
                m_ties++;
            end
            if (v < m_min) m_min = v;
        end
        m_n++;
    endtask

    task automatic check_res4(input string tag, input logic [7:0] emax, input logic [3:0] eties,
                              input logic [7:0] emin);
        check({tag, "_valid"}, 32'(ov4), 32'd1);
        check({tag, "_max"}, 32'(om4), 32'(emax));
        check({tag, "_ties"}, 32'(ot4), 32'(eties));
`ifdef MAX_ACCUM_MIN_EN
        check({tag, "_min"}, 32'(omin4), 32'(emin));
`else
        if (emin != emin) check({tag, "_min"}, 32'(emin), 32'(emin));
`endif
    endtask

    logic [7:0] vec_a [4];
    logic [7:0] d;
    int         n;

    initial begin
        rst_n = 1'b0;
        iv4 = 1'b0; id4 = 8'h00; or4 = 1'b0;
        iv16 = 1'b0; id16 = 8'h00; or16 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(ir4), 32'd0);
        check("rst_out_valid", 32'(ov4), 32'd0);
        check("rst_out_max", 32'(om4), 32'h00);
        check("rst_out_ties", 32'(ot4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(ir4), 32'd1);
        check("rel_in_ready16", 32'(ir16), 32'd1);

        // 03,05,02,05 with out_ready held high
        or4 = 1'b1;
        vec_a = '{8'h03, 8'h05, 8'h02, 8'h05};
        for (int i = 0; i < 3; i++) send4(vec_a[i]);
        check("f1_not_done", 32'(ov4), 32'd0);
        send4(vec_a[3]);
        check_res4("f1", 8'h05, 4'd1, 8'h02);
        @(negedge clk);
        check("f1_consumed", 32'(ov4), 32'd0);
        check("f1_ready_back", 32'(ir4), 32'd1);

        // Negative samples, including negative zero
        vec_a = '{8'h81, 8'h85, 8'h80, 8'hFF};
        for (int i = 0; i < 4; i++) send4(vec_a[i]);
        check_res4("f2", 8'h00, 4'd0, 8'h81);
        @(negedge clk);
        or4 = 1'b0;

        // FRAME_LEN=16, all 07: the tie count reaches 15
        for (int i = 0; i < 16; i++) send16(8'h07);
        check("f16_valid", 32'(ov16), 32'd1);
        check("f16_max", 32'(om16), 32'h07);
        check("f16_ties", 32'(ot16), 32'd15);
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check("f16_consumed", 32'(ov16), 32'd0);

        // Back-pressure: the result is held and inputs are ignored
        vec_a = '{8'h03, 8'h09, 8'h09, 8'h01};
        for (int i = 0; i < 4; i++) send4(vec_a[i]);
        check_res4("bp", 8'h09, 4'd1, 8'h01);
        for (int c = 0; c < 5; c++) begin
            iv4 = c[0];
            id4 = 8'h7F;
            @(negedge clk);
            check("bp_in_ready", 32'(ir4), 32'd0);
            check("bp_valid", 32'(ov4), 32'd1);
            check("bp_max", 32'(om4), 32'h09);
            check("bp_ties", 32'(ot4), 32'd1);
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        check("bp_ready_back", 32'(ir4), 32'd1);
        check("bp_valid_clr", 32'(ov4), 32'd0);
        check("bp_max_hold", 32'(om4), 32'h09);
        for (int i = 0; i < 4; i++) send4(8'h01);
        check_res4("bp_next", 8'h01, 4'd3, 8'h01);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;

        // Reset mid-frame discards the partial frame
        send4(8'h7F);
        send4(8'h7F);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ov4), 32'd0);
        check("mid_rst_max", 32'(om4), 32'h00);
        check("mid_rst_ties", 32'(ot4), 32'd0);
        check("mid_rst_in_ready", 32'(ir4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vec_a = '{8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 4; i++) send4(vec_a[i]);
        check_res4("post_rst", 8'h40, 4'd0, 8'h10);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;

        // 100 random frames with random input gaps and consumer stalls
        for (int f = 0; f < 100; f++) begin
            m_n = 0;
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                or4 = 1'($urandom_range(0, 1));
                d = {1'($urandom_range(0, 1)), 4'b0000, 3'($urandom_range(0, 7))};
                model_add(d);
                send4(d);
            end
            or4 = 1'b0;
            n = 0;
            while (!ov4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_res4("rnd", m_max[7:0], m_ties[3:0], m_min[7:0]);
            or4 = 1'b1;
            @(negedge clk);
            or4 = 1'b0;
            check("rnd_consumed", 32'(ov4), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_accum.md
MAX_ACCUM -- requirements
Module: max_accum

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, giving samples per frame; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid sample.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-006 The block SHALL have port in_data, input, 8 bits: sample in sign-magnitude form (bit 7 is the sign, bits 6:0 the magnitude).
REQ-007 The block SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port out_max, output, 8 bits: the frame maximum in two's complement.
REQ-010 The block SHALL have port out_ties, output, 4 bits: count of samples equal to the running maximum, excluding the sample that set it.

Function
REQ-011 The block SHALL accept a sample only on a cycle where in_valid and in_ready are both 1.
REQ-012 The block SHALL convert each sample as follows: sign 0 gives the value +magnitude; sign 1 gives the two's-complement negation of the magnitude; 8'h80 (negative zero) gives 8'h00. The result range is -127..+127.
REQ-013 The FSM SHALL have states FIRST, ACCUM and HOLD; FIRST is the reset state.
REQ-014 In FIRST, on accept: running max <= converted sample, ties <= 0, count <= 1, then go to ACCUM.
REQ-015 In ACCUM, on accept, the block SHALL apply these rules, where the comparison is signed:
- sample > running max: max <= sample, ties <= 0.
- sample == running max: ties <= ties + 1, saturating at 15.
- sample < running max: no change.
- In all three cases, count increments.
REQ-016 When the accepted sample makes count equal FRAME_LEN, the FSM SHALL go to HOLD, and out_valid SHALL be 1 on the next cycle. Latency from the last accept to out_valid is 1 cycle.
REQ-017 in_ready SHALL be 1 in FIRST and ACCUM, and 0 in HOLD.
REQ-018 In HOLD, out_max and out_ties SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 In HOLD with out_ready=1, the result SHALL be consumed that cycle, and the FSM SHALL go to FIRST. in_ready returns to 1 the following cycle; samples are never accepted in the same cycle as the handoff.
REQ-020 out_ready SHALL be ignored outside HOLD.
REQ-021 in_valid SHALL be ignored while in_ready=0; no sample is lost or double-counted.
REQ-022 out_max and out_ties SHALL update only on the transition into HOLD, and SHALL hold their last values otherwise.

Reset
REQ-023 rst_n=0 SHALL immediately force: state FIRST, count 0, running max 0, ties 0, out_valid 0, out_max 8'h00, out_ties 0.
REQ-024 in_ready SHALL be 0 while rst_n=0, and SHALL be 1 from the first clock after release.
REQ-025 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending result; there is no recovery of the discarded data.

Configuration
REQ-026 With macro MAX_ACCUM_MIN_EN defined, the block SHALL add port out_min (output, 8 bits, two's complement). out_min tracks the signed frame minimum with the same load, update and hold rules as out_max (no tie count), and resets to 8'h00.
REQ-027 Without MAX_ACCUM_MIN_EN, the out_min port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 FRAME_LEN=4, samples 03,05,02,05 with out_ready=1 -> out_valid one cycle after the 4th accept; out_max=05, out_ties=1.
REQ-029 FRAME_LEN=4, samples 81,85,80,FF (i.e. -1,-5,-0,-127) -> out_max=00 (from negative zero), out_ties=0; with MAX_ACCUM_MIN_EN, out_min=81 (-127).
REQ-030 FRAME_LEN=16, all samples 07 -> out_max=07, out_ties=15 (saturated).
REQ-031 FRAME_LEN=4, out_ready held 0 for 5 cycles after the frame completes -> in_ready=0 throughout, outputs stable, in_valid pulses ignored; out_ready=1 -> in_ready=1 next cycle, and the next frame is independent.
REQ-032 rst_n pulsed low after 2 of 4 samples -> outputs 0 immediately; 4 new samples 10,20,30,40 -> out_max=40, out_ties=0 with no contribution from the discarded samples.
REQ-033 Random in_valid/out_ready gaps across 100 frames against a reference model -> every result matches, with no drops or duplicates.
